// File: rtl/bram_dp_model.sv
// ============================================================================
// Module   : bram_dp_model
// Brief    : True dual-port byte-strobed block-RAM model with registered,
//            fixed-latency read pipelines and sticky collision / range flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bram_dp_model #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 65536,
    parameter int ADDR_W    = 32,
    parameter int BYTE_ADDR = 1,
    parameter int RD_LAT    = 1,
    parameter int WR_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic [DATA_W/8-1:0]   a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic [DATA_W/8-1:0]   b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid,
    input  logic                  clr_flags,
    output logic                  oob_err,
    output logic                  collision
);

    localparam int          LANES   = DATA_W / 8;
    localparam int          OFF_W   = (BYTE_ADDR != 0) ? $clog2(LANES) : 0;
    localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] DEPTH64 = 64'(DEPTH);

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [LANES-1:0]  we);
        merge_bytes = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) merge_bytes[8*i +: 8] = new_w[8*i +: 8];
        end
    endfunction

    // Contents are deliberately outside the reset domain.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic [ADDR_W-1:0] a_idx, b_idx;
    logic [MEM_AW-1:0] a_widx, b_widx;
    logic              a_inr, b_inr, a_wr, b_wr;
    logic [DATA_W-1:0] a_old, b_old, a_rd_d, b_rd_d;
    logic              coll_evt, oob_evt;
    logic              oob_d, coll_d;

    assign a_idx  = a_addr >> OFF_W;
    assign b_idx  = b_addr >> OFF_W;
    assign a_inr  = (64'(a_idx) < DEPTH64);
    assign b_inr  = (64'(b_idx) < DEPTH64);
    assign a_widx = a_idx[MEM_AW-1:0];
    assign b_widx = b_idx[MEM_AW-1:0];
    assign a_wr   = a_en & a_inr & (|a_we);
    assign b_wr   = b_en & b_inr & (|b_we);

    // Cross-port readers always see the pre-edge word.
    assign a_old  = a_inr ? mem_q[a_widx] : '0;
    assign b_old  = b_inr ? mem_q[b_widx] : '0;
    assign a_rd_d = ((WR_FIRST != 0) && a_wr) ? merge_bytes(a_old, a_wdata, a_we) : a_old;
    assign b_rd_d = ((WR_FIRST != 0) && b_wr) ? merge_bytes(b_old, b_wdata, b_we) : b_old;

    assign coll_evt = a_en & b_en & a_inr & b_inr & (a_idx == b_idx) & ((|a_we) | (|b_we));
    assign oob_evt  = (a_en & ~a_inr) | (b_en & ~b_inr);
    assign oob_d    = (oob_err & ~clr_flags) | oob_evt;
    assign coll_d   = (collision & ~clr_flags) | coll_evt;

    // Port B lanes land first so port A overrides shared lanes.
    always_ff @(posedge clk) begin
        if (b_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (b_we[i]) mem_q[b_widx][8*i +: 8] <= b_wdata[8*i +: 8];
            end
        end
        if (a_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (a_we[i]) mem_q[a_widx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    logic [RD_LAT-1:0] a_vld_q, b_vld_q;
    logic [DATA_W-1:0] a_dat_q [RD_LAT];
    logic [DATA_W-1:0] b_dat_q [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_vld_q   <= '0;
            b_vld_q   <= '0;
            oob_err   <= 1'b0;
            collision <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                a_dat_q[i] <= '0;
                b_dat_q[i] <= '0;
            end
        end else begin
            oob_err    <= oob_d;
            collision  <= coll_d;
            a_vld_q[0] <= a_en;
            b_vld_q[0] <= b_en;
            if (a_en) a_dat_q[0] <= a_rd_d;
            if (b_en) b_dat_q[0] <= b_rd_d;
            // Data only advances behind a valid so rdata holds across bubbles.
            for (int i = 1; i < RD_LAT; i++) begin
                a_vld_q[i] <= a_vld_q[i-1];
                b_vld_q[i] <= b_vld_q[i-1];
                if (a_vld_q[i-1]) a_dat_q[i] <= a_dat_q[i-1];
                if (b_vld_q[i-1]) b_dat_q[i] <= b_dat_q[i-1];
            end
        end
    end

    assign a_rdata  = a_dat_q[RD_LAT-1];
    assign b_rdata  = b_dat_q[RD_LAT-1];
    assign a_rvalid = a_vld_q[RD_LAT-1];
    assign b_rvalid = b_vld_q[RD_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_bram_dp_model.sv
// ============================================================================
// Module   : tb_bram_dp_model
// Brief    : Scoreboard bench driving three bram_dp_model variants
//            (RD_LAT 1/3/4, WR_FIRST 0/1/0) from one shared directed stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bram_dp_model;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_en = 1'b0, b_en = 1'b0, clr_flags = 1'b0;
    logic [3:0]  a_we = '0, b_we = '0;
    logic [15:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;

    logic        rv  [6];
    logic [31:0] rd  [6];
    logic        oob [3];
    logic        col [3];

    exp_t sb [6][$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_dp_model #(.DATA_W(32), .DEPTH(64), .ADDR_W(16), .BYTE_ADDR(1), .RD_LAT(1), .WR_FIRST(0)) d1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(rd[0]), .a_rvalid(rv[0]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(rd[3]), .b_rvalid(rv[3]),
        .clr_flags(clr_flags), .oob_err(oob[0]), .collision(col[0]));

    bram_dp_model #(.DATA_W(32), .DEPTH(64), .ADDR_W(16), .BYTE_ADDR(1), .RD_LAT(3), .WR_FIRST(1)) d3 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(rd[1]), .a_rvalid(rv[1]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(rd[4]), .b_rvalid(rv[4]),
        .clr_flags(clr_flags), .oob_err(oob[1]), .collision(col[1]));

    bram_dp_model #(.DATA_W(32), .DEPTH(64), .ADDR_W(16), .BYTE_ADDR(1), .RD_LAT(4), .WR_FIRST(0)) d4 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(rd[2]), .a_rvalid(rv[2]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(rd[5]), .b_rvalid(rv[5]),
        .clr_flags(clr_flags), .oob_err(oob[2]), .collision(col[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Queue index k: 0..2 = port A of d1/d3/d4, 3..5 = port B.
    always @(negedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
                check($sformatf("rvalid[%0d]@%0d", k, cyc), {31'b0, rv[k]}, 32'd1);
                check($sformatf("rdata[%0d]@%0d", k, cyc), rd[k], sb[k][0].d);
                void'(sb[k].pop_front());
            end else if (rv[k]) begin
                check($sformatf("spurious_rvalid[%0d]@%0d", k, cyc), 32'd1, 32'd0);
            end
        end
    end

    // Expected data: e0 for WR_FIRST=0 variants, e1 for the WR_FIRST=1 variant.
    task automatic acc(input logic ae, input logic [3:0] awe, input logic [15:0] aad,
                       input logic [31:0] awd, input logic [31:0] ae0, input logic [31:0] ae1,
                       input logic be, input logic [3:0] bwe, input logic [15:0] bad,
                       input logic [31:0] bwd, input logic [31:0] be0, input logic [31:0] be1,
                       input logic clr = 1'b0);
        @(negedge clk);
        a_en = ae; a_we = awe; a_addr = aad; a_wdata = awd;
        b_en = be; b_we = bwe; b_addr = bad; b_wdata = bwd;
        clr_flags = clr;
        if (ae) begin
            sb[0].push_back('{ae0, cyc + 1});
            sb[1].push_back('{ae1, cyc + 3});
            sb[2].push_back('{ae0, cyc + 4});
        end
        if (be) begin
            sb[3].push_back('{be0, cyc + 1});
            sb[4].push_back('{be1, cyc + 3});
            sb[5].push_back('{be0, cyc + 4});
        end
    endtask

    task automatic idle(input logic clr = 1'b0);
        @(negedge clk);
        a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
        clr_flags = clr;
    endtask

    task automatic flags(input string nm, input logic exp_col, input logic exp_oob);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_collision[%0d]", nm, k), {31'b0, col[k]}, {31'b0, exp_col});
            check($sformatf("%s_oob[%0d]", nm, k), {31'b0, oob[k]}, {31'b0, exp_oob});
        end
    endtask

    task automatic outs_zero(input string nm);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s_rdata[%0d]", nm, k), rd[k], 32'h0);
            check($sformatf("%s_rvalid[%0d]", nm, k), {31'b0, rv[k]}, 32'd0);
        end
        flags(nm, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        outs_zero("reset");
        rst = 1'b1;

        acc(1, 4'hF, 16'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 4'h0, 16'h0,  32'h0, 32'h0, 32'h0);
        acc(1, 4'h0, 16'h13, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1, 4'h0, 16'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        idle();
        flags("both_read", 1'b0, 1'b0);

        acc(1, 4'hF, 16'h10, 32'h11223344, 32'hDEADBEEF, 32'h11223344, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
        acc(1, 4'h5, 16'h10, 32'hAABBCCDD, 32'h11223344, 32'h11BB33DD, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
        acc(0, 4'h0, 16'h0,  32'h0,        32'h0,        32'h0,        1, 4'h0, 16'h10, 32'h0, 32'h11BB33DD, 32'h11BB33DD);

        acc(1, 4'hF, 16'h0, 32'hA0, 32'h0, 32'hA0, 1, 4'hF, 16'h4, 32'hA1, 32'h0, 32'hA1);
        acc(1, 4'hF, 16'h8, 32'hA2, 32'h0, 32'hA2, 0, 4'h0, 16'h0, 32'h0,  32'h0, 32'h0);
        acc(1, 4'h0, 16'h0, 32'h0,  32'hA0, 32'hA0, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
        acc(1, 4'h0, 16'h4, 32'h0,  32'hA1, 32'hA1, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
        acc(1, 4'h0, 16'h8, 32'h0,  32'hA2, 32'hA2, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
        idle();
        flags("diff_words", 1'b0, 1'b0);

        acc(1, 4'h3, 16'h1C, 32'h11111111, 32'h0, 32'h00001111, 1, 4'h6, 16'h1C, 32'h22222222, 32'h0, 32'h00222200);
        idle();
        flags("dual_write", 1'b1, 1'b0);
        idle(1'b1);
        idle();
        flags("clr", 1'b0, 1'b0);
        acc(1, 4'h0, 16'h1C, 32'h0, 32'h00221111, 32'h00221111, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);

        acc(1, 4'hF, 16'h8, 32'h12345678, 32'hA2, 32'h12345678, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
        acc(1, 4'h1, 16'h8, 32'h000000FF, 32'h12345678, 32'h123456FF,
            1, 4'h0, 16'h8, 32'h0, 32'h12345678, 32'h12345678, 1'b1);
        idle();
        flags("set_wins", 1'b1, 1'b0);
        idle(1'b1);
        idle();
        flags("clr2", 1'b0, 1'b0);
        acc(1, 4'h0, 16'h8, 32'h0, 32'h123456FF, 32'h123456FF, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);

        acc(1, 4'hF, 16'h100, 32'hCAFEBABE, 32'h0, 32'h0, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
        idle();
        flags("oob_write", 1'b0, 1'b1);
        acc(1, 4'h0, 16'h0, 32'h0, 32'hA0, 32'hA0, 0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
        idle(1'b1);
        idle();
        flags("oob_clr", 1'b0, 1'b0);
        repeat (4) idle();

        // Reset two cycles after issue: only the RD_LAT=1 results escape.
        acc(1, 4'h0, 16'h10, 32'h0, 32'h11BB33DD, 32'h11BB33DD, 1, 4'h0, 16'h104, 32'h0, 32'h0, 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) sb[k].delete();
        #1;
        outs_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) idle();

        acc(1, 4'h0, 16'h10, 32'h0, 32'h11BB33DD, 32'h11BB33DD, 1, 4'h0, 16'h1C, 32'h0, 32'h00221111, 32'h00221111);
        acc(1, 4'h0, 16'h8,  32'h0, 32'h123456FF, 32'h123456FF, 1, 4'h0, 16'h4,  32'h0, 32'hA1, 32'hA1);
        repeat (6) idle();

        for (int k = 0; k < 6; k++) begin
            check($sformatf("drained[%0d]", k), 32'(sb[k].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
